// File: rtl/prog_load_mem.sv
// Program-load memory: valid/ready word loader with count, checksum and overflow
// tracking, plus a registered fetch port enabled once a load session completes.
module prog_load_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [DATA_W-1:0] prog_in,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum,
  output logic              overflow,
  output logic              load_done,
  output logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic              full;
  logic              accept;
  logic              reload;
  logic              in_range;

  assign full       = (word_count == FULL_CNT);
  assign prog_ready = (state == LOAD) && load_en && !full;
  assign accept     = prog_valid && prog_ready;
  // Fetches on the reload transition edge are dropped even though mem_ready is still high.
  assign reload     = (state == READY) && load_en;
  assign in_range   = ({1'b0, fetch_addr} < word_count);

  always_ff @(posedge clk) begin
    if (accept) mem[ptr] <= prog_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      word_count  <= '0;
      checksum    <= '0;
      overflow    <= 1'b0;
      load_done   <= 1'b0;
      mem_ready   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (load_en) begin
            state      <= LOAD;
            ptr        <= '0;
            word_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
            mem_ready  <= 1'b0;
          end
        end
        LOAD: begin
          if (!load_en) begin
            state     <= READY;
            load_done <= 1'b1;
            mem_ready <= 1'b1;
          end else if (prog_valid) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              ptr        <= ptr + 1'b1;
              word_count <= word_count + 1'b1;
              checksum   <= checksum + prog_in;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (fetch_en && mem_ready && !reload) begin
        fetch_valid <= 1'b1;
        fetch_data  <= in_range ? mem[fetch_addr] : '0;
      end else begin
        fetch_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_load_mem.sv
// Bench for prog_load_mem: fetch results are scoreboarded against a reference
// program image; a DEPTH=4 instance covers the full/overflow corner.
module tb_prog_load_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, prog_valid, fetch_en;
  logic [15:0] prog_in;
  logic [5:0]  fetch_addr;
  logic        prog_ready, fetch_valid, overflow, load_done, mem_ready;
  logic [15:0] fetch_data, checksum;
  logic [6:0]  word_count;

  logic        l4_en, l4_valid, l4_fen;
  logic [15:0] l4_in;
  logic [1:0]  l4_faddr;
  logic        l4_ready, l4_fvalid, l4_ovf, l4_done, l4_mready;
  logic [15:0] l4_fdata, l4_sum;
  logic [2:0]  l4_cnt;

  always #5 clk = ~clk;

  prog_load_mem dut (
    .clk(clk), .reset(reset), .load_en(load_en), .prog_in(prog_in),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .word_count(word_count), .checksum(checksum), .overflow(overflow),
    .load_done(load_done), .mem_ready(mem_ready)
  );

  prog_load_mem #(.DATA_W(16), .DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .reset(reset), .load_en(l4_en), .prog_in(l4_in),
    .prog_valid(l4_valid), .prog_ready(l4_ready), .fetch_en(l4_fen),
    .fetch_addr(l4_faddr), .fetch_data(l4_fdata), .fetch_valid(l4_fvalid),
    .word_count(l4_cnt), .checksum(l4_sum), .overflow(l4_ovf),
    .load_done(l4_done), .mem_ready(l4_mready)
  );

  typedef struct {
    logic [15:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic [15:0] m_mem [64];
  int unsigned m_cnt;
  logic [15:0] m_sum;
  logic [15:0] prog6 [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_load();
    load_en = 1'b1;
    m_cnt   = 0;
    m_sum   = '0;
    step();
  endtask

  task automatic put(input logic [15:0] w);
    prog_valid = 1'b1;
    prog_in    = w;
    step();
    m_mem[m_cnt] = w;
    m_cnt++;
    m_sum += w;
    prog_valid = 1'b0;
  endtask

  task automatic end_load(input string tag);
    load_en = 1'b0;
    step();
    chk({tag, "_load_done"}, 32'(load_done), 32'd1);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
    chk({tag, "_word_count"}, 32'(word_count), 32'(m_cnt));
    chk({tag, "_checksum"}, 32'(checksum), 32'(m_sum));
    prog_valid = 1'b0;
    step();
    chk({tag, "_load_done_pulse"}, 32'(load_done), 32'd0);
  endtask

  task automatic fetch(input logic [5:0] a);
    exp_t e;
    fetch_en   = 1'b1;
    fetch_addr = a;
    e.data = (32'(a) < m_cnt) ? m_mem[a] : 16'h0000;
    e.due  = cyc + 1;
    sb_q.push_back(e);
    step();
  endtask

  always @(posedge clk) cyc++;

  // Each queued fetch must appear exactly on its due cycle; any other fetch_valid is spurious.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_e = sb_q.pop_front();
      chk("fetch_valid", 32'(fetch_valid), 32'd1);
      chk("fetch_data", 32'(fetch_data), 32'(sb_e.data));
    end else if (fetch_valid) begin
      chk("spurious_fetch_valid", 32'(fetch_valid), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog6 = '{16'h0005, 16'hEC10, 16'h0001, 16'hE308, 16'h0000, 16'hE007};
    reset = 1'b0; load_en = 1'b0; prog_valid = 1'b0; prog_in = '0;
    fetch_en = 1'b0; fetch_addr = '0;
    l4_en = 1'b0; l4_valid = 1'b0; l4_in = '0; l4_fen = 1'b0; l4_faddr = '0;
    m_cnt = 0; m_sum = '0;
    step(); step();
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_data", 32'(fetch_data), 32'd0);
    chk("rst_prog_ready", 32'(prog_ready), 32'd0);
    reset = 1'b1;
    step();

    // Nominal 6-word load
    start_load();
    chk("nom_prog_ready", 32'(prog_ready), 32'd1);
    for (int i = 0; i < 6; i++) put(prog6[i]);
    end_load("nom");
    chk("nom_checksum_const", 32'(checksum), 32'h0000AF25);
    chk("nom_overflow", 32'(overflow), 32'd0);

    fetch(6'd3); fetch(6'd0); fetch(6'd1); fetch(6'd5);
    fetch_en = 1'b0;
    step(); step();
    chk("fetch_data_hold", 32'(fetch_data), 32'h0000E007);
    fetch(6'd6);
    fetch_en = 1'b0;
    step();

    // Reload: fetches during the transition and LOAD are ignored
    fetch_en = 1'b1; fetch_addr = 6'd0;
    start_load();
    chk("rl_mem_ready", 32'(mem_ready), 32'd0);
    put(16'h0007);
    fetch_en = 1'b0;
    put(16'h0008);
    end_load("rl");
    chk("rl_checksum_const", 32'(checksum), 32'h0000000F);
    chk("rl_overflow", 32'(overflow), 32'd0);
    fetch(6'd1);
    fetch_en = 1'b0;
    step();

    // Gap in prog_valid, and a word offered as load_en falls
    start_load();
    put(16'hAAAA);
    prog_valid = 1'b0; prog_in = 16'hBEEF;
    step();
    put(16'h5555);
    prog_valid = 1'b1; prog_in = 16'h1234;
    end_load("gap");
    chk("gap_checksum_const", 32'(checksum), 32'h0000FFFF);
    fetch(6'd2); fetch(6'd1);
    fetch_en = 1'b0;
    step();

    // Reset mid-load
    start_load();
    put(16'h0001); put(16'h0002); put(16'h0003);
    reset = 1'b0; load_en = 1'b0;
    #1;
    chk("mrst_word_count", 32'(word_count), 32'd0);
    chk("mrst_checksum", 32'(checksum), 32'd0);
    chk("mrst_mem_ready", 32'(mem_ready), 32'd0);
    chk("mrst_fetch_data", 32'(fetch_data), 32'd0);
    step();
    reset = 1'b1;
    m_cnt = 0; m_sum = '0;
    fetch_en = 1'b1; fetch_addr = 6'd0;
    step();
    fetch_en = 1'b0;
    step();
    chk("mrst_no_fetch", 32'(fetch_valid), 32'd0);
    start_load();
    put(16'h1234);
    end_load("fresh");
    fetch(6'd0);
    fetch_en = 1'b0;
    step();

    // Full / overflow on the 4-deep instance
    l4_en = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) chk("ovf_ready_before_full", 32'(l4_ready), 32'd1);
      if (i == 5) chk("ovf_ready_full", 32'(l4_ready), 32'd0);
      l4_valid = 1'b1; l4_in = 16'(i);
      step();
    end
    l4_valid = 1'b0;
    chk("ovf_word_count", 32'(l4_cnt), 32'd4);
    chk("ovf_checksum", 32'(l4_sum), 32'h0000000A);
    chk("ovf_flag", 32'(l4_ovf), 32'd1);
    l4_en = 1'b0;
    step();
    chk("ovf_mem_ready", 32'(l4_mready), 32'd1);
    chk("ovf_sticky", 32'(l4_ovf), 32'd1);
    l4_fen = 1'b1; l4_faddr = 2'd3;
    step();
    l4_fen = 1'b0;
    chk("ovf_fetch_valid", 32'(l4_fvalid), 32'd1);
    chk("ovf_fetch_data", 32'(l4_fdata), 32'h00000004);

    step(); step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
